cmd_frame_sender: RTL and testbench

Transmit-side counterpart to `cmd_manager`: accepts a response command with two argument bytes, computes an 8-bit CRC over them, and emits the 4-byte frame `cmd, arg1, arg2, crc` one byte at a time to the byte-level serializer. It uses the same toggle-style byte handshake the receive path consumes. It sits between the cart's command logic and the byte shifter driving the link back to the host.

---
 rtl/cmd_frame_pkg.sv | 37 +++
 rtl/crc8_serial.sv | 40 ++++
 rtl/cmd_frame_sender.sv | 176 +++++++++++++++++
 tb/tb_cmd_frame_sender.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the command frame transmit path.
// Holds the FSM state encoding, frame byte indices and the CRC-8 defaults
// that the receive-side command checker also uses.
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CRC     = 3'd1,
    PRESENT = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int FRAME_BYTES = 4;

  localparam logic [1:0] IDX_CMD  = 2'd0;
  localparam logic [1:0] IDX_ARG1 = 2'd1;
  localparam logic [1:0] IDX_ARG2 = 2'd2;
  localparam logic [1:0] IDX_CRC  = 2'd3;

  // CRC-8, MSB first, x^8 implicit, no reflection, no final XOR.
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // Number of payload bits folded into the CRC (cmd, arg1, arg2).
  localparam int PAYLOAD_BITS = 24;

  // One serial CRC step: shift in a single message bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       bit_in,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine: one message bit per cycle in which step_i is high.
// Ports: clk_i/reset_ni (async active-low), clear_i reloads INIT (wins over
// step_i), step_i advances one bit using bit_in_i, crc_o is the running CRC.
module crc8_serial
  import cmd_frame_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       clear_i,
  input  logic       step_i,
  input  logic       bit_in_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = INIT;
    end else if (step_i) begin
      crc_d = crc8_step(crc_q, bit_in_i, POLY);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      crc_q <= INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cmd_frame_sender.sv
// Sends a 4-byte response frame (cmd, arg1, arg2, crc) to a byte serializer
// using toggle handshakes: byte_ready_o toggles per new byte, byte_finished_i
// toggles per byte shifted out. Inputs: clk_i, reset_ni (async active-low),
// en_i (freeze), send_i + cmd_i/arg1_i/arg2_i payload, byte_finished_i.
// Outputs: out_byte_o, byte_ready_o, busy_o, crc_o, frame_finished_o (pulse).
module cmd_frame_sender
  import cmd_frame_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY,
  parameter logic [7:0] INIT = CRC8_INIT
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       en_i,
  input  logic       send_i,
  input  logic [7:0] cmd_i,
  input  logic [7:0] arg1_i,
  input  logic [7:0] arg2_i,
  input  logic       byte_finished_i,
  output logic [7:0] out_byte_o,
  output logic       byte_ready_o,
  output logic       busy_o,
  output logic [7:0] crc_o,
  output logic       frame_finished_o
);

  localparam logic [4:0] LAST_BIT = 5'(PAYLOAD_BITS - 1);

  state_e     state_q;
  logic [1:0] idx_q;
  logic [4:0] bitcnt_q;
  logic [7:0] cmd_q, arg1_q, arg2_q;
  logic [7:0] out_byte_q;
  logic       byte_ready_q;
  logic       busy_q;
  logic       frame_finished_q;

  logic       bf_q, bf_qq;
  logic       pending_q, pending_d;

  logic [23:0] payload_w;
  logic [1:0]  idx_next;
  logic [7:0]  next_byte;
  logic        crc_clear, crc_step, crc_bit;
  logic        bit_edge, consume, enter_present;
  logic [7:0]  crc_w;

  assign payload_w = {cmd_q, arg1_q, arg2_q};
  // Counter runs 0..23; bit 23 of the payload is cmd[7], so MSB goes first.
  assign crc_bit   = payload_w[LAST_BIT - bitcnt_q];
  assign crc_clear = en_i && (state_q == IDLE) && send_i;
  assign crc_step  = en_i && (state_q == CRC);

  crc8_serial #(
    .POLY (POLY),
    .INIT (INIT)
  ) u_crc (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (crc_clear),
    .step_i   (crc_step),
    .bit_in_i (crc_bit),
    .crc_o    (crc_w)
  );

  // Handshake edge detection runs even while en_i is low so that an
  // acknowledgement arriving during a pause is not lost.
  assign bit_edge      = bf_q ^ bf_qq;
  assign consume       = en_i && (state_q == WAIT) && pending_q;
  assign enter_present = (crc_step && (bitcnt_q == LAST_BIT)) ||
                         (consume && (idx_q != IDX_CRC));

  always_comb begin
    pending_d = pending_q;
    if (consume)  pending_d = 1'b0;
    if (bit_edge) pending_d = 1'b1;
    // A fresh byte is going out: anything seen so far acknowledges an
    // older byte (or none at all) and must not count.
    if (enter_present) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bf_q      <= 1'b0;
      bf_qq     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      bf_q      <= byte_finished_i;
      bf_qq     <= bf_q;
      pending_q <= pending_d;
    end
  end

  assign idx_next = idx_q + 2'd1;

  always_comb begin
    next_byte = cmd_q;
    case (idx_next)
      IDX_CMD:  next_byte = cmd_q;
      IDX_ARG1: next_byte = arg1_q;
      IDX_ARG2: next_byte = arg2_q;
      IDX_CRC:  next_byte = crc_w;
      default:  next_byte = cmd_q;
    endcase
  end

  // Frame sequencer. All outputs are registered here so they change exactly
  // on the state transitions that define them.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q          <= IDLE;
      idx_q            <= IDX_CMD;
      bitcnt_q         <= 5'd0;
      cmd_q            <= 8'h00;
      arg1_q           <= 8'h00;
      arg2_q           <= 8'h00;
      out_byte_q       <= 8'h00;
      byte_ready_q     <= 1'b0;
      busy_q           <= 1'b0;
      frame_finished_q <= 1'b0;
    end else if (en_i) begin
      case (state_q)
        IDLE: begin
          if (send_i) begin
            cmd_q    <= cmd_i;
            arg1_q   <= arg1_i;
            arg2_q   <= arg2_i;
            idx_q    <= IDX_CMD;
            bitcnt_q <= 5'd0;
            busy_q   <= 1'b1;
            state_q  <= CRC;
          end
        end
        CRC: begin
          bitcnt_q <= bitcnt_q + 5'd1;
          if (bitcnt_q == LAST_BIT) begin
            out_byte_q   <= cmd_q;
            byte_ready_q <= ~byte_ready_q;
            state_q      <= PRESENT;
          end
        end
        PRESENT: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (pending_q) begin
            if (idx_q == IDX_CRC) begin
              frame_finished_q <= 1'b1;
              busy_q           <= 1'b0;
              state_q          <= DONE;
            end else begin
              idx_q        <= idx_next;
              out_byte_q   <= next_byte;
              byte_ready_q <= ~byte_ready_q;
              state_q      <= PRESENT;
            end
          end
        end
        DONE: begin
          frame_finished_q <= 1'b0;
          state_q          <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_byte_o       = out_byte_q;
  assign byte_ready_o     = byte_ready_q;
  assign busy_o           = busy_q;
  assign crc_o            = crc_w;
  assign frame_finished_o = frame_finished_q;

endmodule

// File: tb/tb_cmd_frame_sender.sv
module tb_cmd_frame_sender;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       send;
  logic [7:0] cmd, arg1, arg2;
  logic       bf_ser = 1'b0;
  logic       bf_man = 1'b0;
  logic       byte_finished;
  logic [7:0] out_byte;
  logic       byte_ready;
  logic       busy;
  logic [7:0] crc;
  logic       frame_finished;

  assign byte_finished = bf_ser ^ bf_man;

  always #5 clk = ~clk;

  cmd_frame_sender dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .en_i             (en),
    .send_i           (send),
    .cmd_i            (cmd),
    .arg1_i           (arg1),
    .arg2_i           (arg2),
    .byte_finished_i  (byte_finished),
    .out_byte_o       (out_byte),
    .byte_ready_o     (byte_ready),
    .busy_o           (busy),
    .crc_o            (crc),
    .frame_finished_o (frame_finished)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Serializer model and monitor: records every presented byte, counts
  // frame_finished pulses and acknowledges each byte ser_delay cycles later.
  logic [7:0] got_q[$];
  int         br_edges = 0;
  int         ff_cnt   = 0;
  int         ser_cnt  = 0;
  int         ser_delay = 2;
  logic       br_prev  = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      br_prev = 1'b0;
      ser_cnt = 0;
      bf_ser  = 1'b0;
    end else begin
      if (frame_finished === 1'b1) ff_cnt++;
      if (byte_ready !== br_prev) begin
        br_prev = byte_ready;
        got_q.push_back(out_byte);
        br_edges++;
        ser_cnt = ser_delay;
      end else if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) bf_ser = ~bf_ser;
      end
    end
  end

  // Reference CRC: remainder of M(x)*x^8 divided by x^8+x^2+x+1 (init 0).
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [31:0] r;
    r = {c, a, b, 8'h00};
    for (int i = 31; i >= 8; i--)
      if (r[i]) r = r ^ (32'h0000_0107 << (i - 8));
    return r[7:0];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    br_edges = 0;
    ff_cnt   = 0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] b);
    cmd = c; arg1 = a; arg2 = b; send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_ff(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (frame_finished === 1'b1) ok = 1'b1;
    end
    tick();
    tick();
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (got_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b1; send = 1'b0;
    cmd = 8'h00; arg1 = 8'h00; arg2 = 8'h00;
    repeat (3) tick();
    n_checks++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset_out_byte: got %h want 00", out_byte); end
    n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (crc !== 8'h00) begin n_fail++; $display("FAIL reset_crc: got %h want 00", crc); end
    n_checks++; if (frame_finished !== 1'b0) begin n_fail++; $display("FAIL reset_frame_finished: got %b want 0", frame_finished); end
    reset_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0 || br_edges != 0) begin n_fail++; $display("FAIL reset_idle: busy %b edges %0d want 0 0", busy, br_edges); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] exp [4];
    logic [7:0] g;
    exp = '{8'h01, 8'h00, 8'h00, 8'h6B};
    clear_obs();
    send_frame(8'h01, 8'h00, 8'h00);
    wait_ff(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: frame_finished not seen within budget"); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      n_checks++; if (g !== exp[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, g, exp[i]); end
    end
    n_checks++; if (crc !== 8'h6B) begin n_fail++; $display("FAIL basic_crc: got %h want 6b", crc); end
    n_checks++; if (ff_cnt != 1) begin n_fail++; $display("FAIL basic_ff_pulses: got %0d want 1", ff_cnt); end
    n_checks++; if (br_edges != 4) begin n_fail++; $display("FAIL basic_edges: got %0d want 4", br_edges); end
  endtask

  task automatic test_zero_timing();
    int cyc;
    logic [7:0] g;
    clear_obs();
    cmd = 8'h00; arg1 = 8'h00; arg2 = 8'h00; send = 1'b1;
    tick();
    send = 1'b0;
    cyc = 1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_rise: got %b want 1", busy); end
    while (frame_finished !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    n_checks++; if (cyc < 45 || cyc > 47) begin n_fail++; $display("FAIL zero_latency: got %0d cycles want 46 +/-1", cyc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_fall: got %b want 0 with frame_finished", busy); end
    tick(); tick();
    n_checks++; if (crc !== 8'h00) begin n_fail++; $display("FAIL zero_crc: got %h want 00", crc); end
    g = (got_q.size() == 4) ? got_q[3] : 8'hxx;
    n_checks++; if (g !== 8'h00) begin n_fail++; $display("FAIL zero_byte3: got %h want 00 (bytes seen %0d)", g, got_q.size()); end
  endtask

  task automatic test_random_frames();
    bit ok;
    logic [7:0] c, a, b, g;
    logic [7:0] exp [4];
    for (int f = 0; f < 6; f++) begin
      c = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
      exp = '{c, a, b, ref_crc(c, a, b)};
      ser_delay = $urandom_range(1, 5);
      clear_obs();
      send_frame(c, a, b);
      wait_ff(400, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: no frame_finished", f); end
      for (int i = 0; i < 4; i++) begin
        g = (i < got_q.size()) ? got_q[i] : 8'hxx;
        n_checks++; if (g !== exp[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h want %h", f, i, g, exp[i]); end
      end
      n_checks++; if (crc !== exp[3]) begin n_fail++; $display("FAIL rand%0d_crc: got %h want %h", f, crc, exp[3]); end
      n_checks++; if (ff_cnt != 1 || br_edges != 4) begin n_fail++; $display("FAIL rand%0d_counts: ff %0d edges %0d want 1 4", f, ff_cnt, br_edges); end
    end
    ser_delay = 2;
  endtask

  task automatic test_send_while_busy();
    bit ok;
    logic [7:0] g;
    logic [7:0] exp [4];
    exp = '{8'hA5, 8'h3C, 8'h0F, ref_crc(8'hA5, 8'h3C, 8'h0F)};
    clear_obs();
    send_frame(8'hA5, 8'h3C, 8'h0F);
    repeat (8) tick();
    send_frame(8'h11, 8'h22, 8'h33);
    wait_bytes(2, 100, ok);
    send_frame(8'h44, 8'h55, 8'h66);
    cmd = 8'h77; arg1 = 8'h88; arg2 = 8'h99;
    wait_ff(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: no frame_finished"); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      n_checks++; if (g !== exp[i]) begin n_fail++; $display("FAIL busy_byte%0d: got %h want %h", i, g, exp[i]); end
    end
    repeat (60) tick();
    n_checks++; if (br_edges != 4 || ff_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_no_second_frame: edges %0d ff %0d busy %b want 4 1 0", br_edges, ff_cnt, busy);
    end
  endtask

  task automatic test_pause();
    bit ok;
    logic [7:0] c, a, b, g, crc_hold;
    logic [7:0] exp [4];
    c = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
    exp = '{c, a, b, ref_crc(c, a, b)};
    clear_obs();
    send_frame(c, a, b);
    repeat (4) tick();
    crc_hold = crc;
    en = 1'b0;
    repeat (10) tick();
    n_checks++; if (crc !== crc_hold || busy !== 1'b1 || br_edges != 0) begin
      n_fail++; $display("FAIL pause_crc_frozen: crc %h busy %b edges %0d want %h 1 0", crc, busy, br_edges, crc_hold);
    end
    en = 1'b1;
    wait_bytes(2, 100, ok);
    en = 1'b0;
    repeat (10) tick();
    n_checks++; if (got_q.size() != 2 || out_byte !== a) begin
      n_fail++; $display("FAIL pause_wait_frozen: bytes %0d out %h want 2 %h", got_q.size(), out_byte, a);
    end
    en = 1'b1;
    repeat (4) tick();
    n_checks++; if (got_q.size() != 3) begin n_fail++; $display("FAIL pause_one_advance: bytes %0d want 3", got_q.size()); end
    wait_ff(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL pause_timeout: no frame_finished"); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      n_checks++; if (g !== exp[i]) begin n_fail++; $display("FAIL pause_byte%0d: got %h want %h", i, g, exp[i]); end
    end
    n_checks++; if (crc !== exp[3] || br_edges != 4) begin n_fail++; $display("FAIL pause_crc: crc %h edges %0d want %h 4", crc, br_edges, exp[3]); end
  endtask

  task automatic test_stray_toggles();
    bit ok;
    logic [7:0] c, g;
    c = 8'($urandom) | 8'h80;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      bf_man = ~bf_man;
      repeat (3) tick();
    end
    send_frame(c, 8'h5A, 8'hC3);
    repeat (2) tick();
    bf_man = ~bf_man;
    repeat (3) tick();
    bf_man = ~bf_man;
    wait_ff(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stray_timeout: no frame_finished"); end
    g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_checks++; if (g !== c) begin n_fail++; $display("FAIL stray_first_byte: got %h want %h", g, c); end
    g = (got_q.size() > 3) ? got_q[3] : 8'hxx;
    n_checks++; if (g !== ref_crc(c, 8'h5A, 8'hC3) || br_edges != 4) begin
      n_fail++; $display("FAIL stray_frame: crc byte %h edges %0d want %h 4", g, br_edges, ref_crc(c, 8'h5A, 8'hC3));
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic [7:0] c, a, b, g;
    logic [7:0] exp [4];
    c = 8'($urandom); a = 8'($urandom) | 8'h01; b = 8'($urandom);
    clear_obs();
    send_frame(c, a, b);
    wait_bytes(2, 100, ok);
    n_checks++; if (!ok || out_byte !== a) begin n_fail++; $display("FAIL rst_pre: bytes %0d out %h want 2 %h", got_q.size(), out_byte, a); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (out_byte !== 8'h00 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_outs: out %h busy %b br %b want 00 0 0", out_byte, busy, byte_ready);
    end
    n_checks++; if (crc !== 8'h00 || frame_finished !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_crc: crc %h ff %b want 00 0", crc, frame_finished);
    end
    tick(); tick();
    reset_n = 1'b1;
    repeat (40) tick();
    n_checks++; if (ff_cnt != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_finish: ff %0d busy %b want 0 0", ff_cnt, busy); end
    c = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
    exp = '{c, a, b, ref_crc(c, a, b)};
    clear_obs();
    send_frame(c, a, b);
    wait_ff(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_new_timeout: no frame_finished"); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      n_checks++; if (g !== exp[i]) begin n_fail++; $display("FAIL rst_new_byte%0d: got %h want %h", i, g, exp[i]); end
    end
    n_checks++; if (ff_cnt != 1 || br_edges != 4) begin n_fail++; $display("FAIL rst_new_counts: ff %0d edges %0d want 1 4", ff_cnt, br_edges); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_timing();
    test_random_frames();
    test_send_while_busy();
    test_pause();
    test_stray_toggles();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
